mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
Shares one registered signed multiplier among NUM_REQ requesters.
- Round-robin arbitration across requesters; at most one issue per cycle.
- Each requester may have one operation outstanding. Its result is held in a per-requester response register until that requester accepts it.
- Sits between the division/compute lanes and the shared multiplier so that lanes do not each instantiate a DSP multiplier.

Parameters:
- DATA_LEN, 32, operand and result width.
- NUM_REQ, 4, number of requesters (>=2).
- MULT_LATENCY, 1, multiplier register stages (>=1), issue to result-register write.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  grant; one-hot or zero; handshake when req_valid[i]&req_ready[i].
- req_a  in  NUM_REQ*DATA_LEN  operand a, requester i at [i*DATA_LEN +: DATA_LEN].
- req_b  in  NUM_REQ*DATA_LEN  operand b, same packing.
- rsp_valid  out  NUM_REQ  result available for requester i.
- rsp_ready  in  NUM_REQ  requester i accepts its result.
- rsp_data  out  NUM_REQ*DATA_LEN  result for requester i, same packing.

Behaviour:
- Arithmetic: result = low DATA_LEN bits of signed a*b; overflow wraps silently. Example: 0x7FFFFFFF*2 = 0xFFFFFFFE.
- State per requester: busy[i], res_reg[i], rsp_valid[i]. Global state: rr_ptr (log2 NUM_REQ bits) and a pipeline of {valid, id} of depth MULT_LATENCY alongside the operands.
- Eligible[i] = req_valid[i] & ~busy[i] & ~reset.
- req_ready is combinational from eligible and rr_ptr. It depends on req_valid; requesters must not make req_valid depend on req_ready.
- Grant goes to the first eligible index searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
- On a grant to g:
  - busy[g] <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Operands and id g enter the multiplier with valid=1.
- With no grant, rr_ptr holds and a bubble (valid=0) enters the pipeline.
- Latency: a grant at cycle T writes res_reg[g] and sets rsp_valid[g] at the edge ending cycle T+MULT_LATENCY. rsp_valid[g] is visible during cycle T+MULT_LATENCY+1 (MULT_LATENCY=1: visible two cycles after the grant cycle).
- Response rules:
  - rsp_data[i] is stable while rsp_valid[i] is set.
  - rsp_valid[i]&rsp_ready[i] clears rsp_valid[i] and busy[i] at that edge.
  - A new grant to i is possible no earlier than the next cycle; the same-cycle re-grant is blocked by busy.
- rsp_ready[i] while rsp_valid[i]=0 is ignored.
- Pipeline never stalls: busy guarantees the response slot is free when the result arrives.
- Per-requester minimum issue interval is MULT_LATENCY+2 cycles when rsp_ready is held high. Aggregate throughput is 1 op/cycle with at least MULT_LATENCY+2 active requesters.
- Reset values:
  - req_ready=0 (forced during reset).
  - rsp_valid=0, busy=0, rr_ptr=0, pipeline valids=0.
  - rsp_data=0.
- Reset mid-operation: in-flight operations are dropped; no rsp_valid appears afterwards for them.

Optional Feature:
- Macro MULT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest eligible index wins, and rr_ptr is not implemented.
- Undefined: round-robin as described above.
- Ports and latency are identical in both modes.

Decomposition:
- Package mult_arb_pkg: function clog2-based ID_W, typedef id_t, and a pipeline-stage struct {valid, id_t id}.
- Sub-module mult_pipe:
  - Registered signed multiplier, low DATA_LEN result, MULT_LATENCY stages, synchronous reset clears output.
  - The arbiter carries the id/valid pipeline alongside it.

Test Plan:
- Single op, NUM_REQ=4, MULT_LATENCY=1, requester 2 with a=7, b=-3, rsp_ready=1. Expect: req_ready[2] in cycle 0; rsp_valid[2] in cycle 2 with rsp_data=0xFFFFFFEB; then cleared.
- All four valid continuously, rsp_ready=1. Expect: grants rotate 0,1,2,3,0… and no requester is granted while busy.
- Backpressure: requester 1 completes with rsp_ready[1]=0 for 5 cycles. Expect: rsp_data[1] stable, req_ready[1]=0 throughout; re-grant possible the cycle after the handshake.
- Overflow: a=0x7FFFFFFF, b=2 -> 0xFFFFFFFE. a=0x80000000, b=-1 -> 0x80000000.
- Reset while two ops are in flight. Expect: all rsp_valid=0 and busy=0 after reset; no later rsp_valid without new grants; rr_ptr restarts at 0.
- With MULT_ARB_FIXED_PRIO_EN defined, requesters 1 and 3 continuously valid. Expect: 1 is granted whenever it is not busy; 3 is granted only in cycles where 1 is busy.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types for the multiplier-sharing arbiter: requester id width and
// the {valid, id} tag that travels alongside the multiplier pipeline.
package mult_arb_pkg;

  localparam int MAX_REQ = 64;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_width(MAX_REQ);

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } pipe_stage_t;

endpackage

// File: rtl/mult_pipe.sv
// Registered signed multiplier returning the low DATA_LEN bits of a*b after
// MULT_LATENCY register stages; synchronous reset clears every stage.
module mult_pipe #(
  parameter int DATA_LEN     = 32,
  parameter int MULT_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  output logic [DATA_LEN-1:0] p
);

  // Low half of a signed product is the same whether computed wide or narrow
  logic signed [DATA_LEN-1:0] prod_low;
  logic [DATA_LEN-1:0] stage_q [MULT_LATENCY];

  assign prod_low = $signed(a) * $signed(b);
  assign p        = stage_q[MULT_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < MULT_LATENCY; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= prod_low;
      for (int s = 1; s < MULT_LATENCY; s++) stage_q[s] <= stage_q[s-1];
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined signed multiplier among NUM_REQ requesters with
// round-robin grants; define MULT_ARB_FIXED_PRIO_EN for lowest-index priority.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int DATA_LEN     = 32,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [NUM_REQ*DATA_LEN-1:0]  rsp_data
);

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] rot_elig;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant_found;
  id_t                grant_id;
  int                 cand;

  logic [NUM_REQ-1:0][DATA_LEN-1:0] a_arr;
  logic [NUM_REQ-1:0][DATA_LEN-1:0] b_arr;
  logic [NUM_REQ-1:0][DATA_LEN-1:0] res_reg;
  logic [DATA_LEN-1:0] sel_a;
  logic [DATA_LEN-1:0] sel_b;
  logic [DATA_LEN-1:0] prod;

  pipe_stage_t pipe_q [MULT_LATENCY];
  pipe_stage_t pipe_out;

  assign a_arr     = req_a;
  assign b_arr     = req_b;
  assign rsp_data  = res_reg;
  assign req_ready = grant_oh;
  assign pipe_out  = pipe_q[MULT_LATENCY-1];
  assign eligible  = req_valid & ~busy & {NUM_REQ{~reset}};

`ifdef MULT_ARB_FIXED_PRIO_EN
  assign rot_elig = eligible;
`else
  localparam int PTR_W = id_width(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;

  // Rotating the request vector lets the search always start at bit 0
  assign rot_elig = NUM_REQ'({eligible, eligible} >> rr_ptr);

  always_ff @(posedge clk) begin
    if (reset)            rr_ptr <= '0;
    else if (grant_found) rr_ptr <= next_ptr;
  end
`endif

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = 0;
`ifndef MULT_ARB_FIXED_PRIO_EN
    next_ptr    = rr_ptr;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = (int'(rr_ptr) + k) % NUM_REQ;
`endif
      if (!grant_found && rot_elig[k]) begin
        grant_found = 1'b1;
        grant_id    = id_t'(cand);
`ifndef MULT_ARB_FIXED_PRIO_EN
        next_ptr    = PTR_W'((cand + 1) % NUM_REQ);
`endif
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = grant_found && (grant_id == id_t'(i));
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_a = a_arr[i];
        sel_b = b_arr[i];
      end
    end
  end

  mult_pipe #(
    .DATA_LEN     (DATA_LEN),
    .MULT_LATENCY (MULT_LATENCY)
  ) u_mult (
    .clk   (clk),
    .reset (reset),
    .a     (sel_a),
    .b     (sel_b),
    .p     (prod)
  );

  // Tag pipeline runs in lockstep with the multiplier stages
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < MULT_LATENCY; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= '{valid: grant_found, id: grant_id};
      for (int s = 1; s < MULT_LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  // busy keeps each response slot free until its result lands, so no stall path
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= '0;
      rsp_valid <= '0;
      res_reg   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
          busy[i]      <= 1'b0;
        end
        if (grant_oh[i]) busy[i] <= 1'b1;
        if (pipe_out.valid && pipe_out.id == id_t'(i)) begin
          res_reg[i]   <= prod;
          rsp_valid[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter against a transaction-level model
// (per-requester slots plus a queue of in-flight results with due cycles).
module tb_mult_share_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int L  = 1;
  localparam int NW = N * W;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [NW-1:0] req_a;
  logic [NW-1:0] req_b;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [NW-1:0] rsp_data;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .DATA_LEN     (W),
    .NUM_REQ      (N),
    .MULT_LATENCY (L)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  typedef struct {
    int         id;
    logic [W-1:0] val;
    int         due;
  } flight_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: who is waiting on a result, what is ready, and what is in flight
  logic [N-1:0]         m_busy;
  logic [N-1:0]         m_rv;
  logic [N-1:0][W-1:0]  m_data;
  int                   m_rr;
  flight_t              inflight[$];

  task automatic checkOutput(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] refMul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pv = 64'(sa * sb);
    return pv[W-1:0];
  endfunction

  function automatic int pickGrant();
    int idx;
    if (reset) return -1;
    for (int k = 0; k < N; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (m_rr + k) % N;
`endif
      if (req_valid[idx] && !m_busy[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      4:       return 32'h0000_0002;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic resetModel();
    m_busy = '0;
    m_rv   = '0;
    m_data = '0;
    m_rr   = 0;
    inflight.delete();
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] v, input logic [N-1:0] rr,
                               input logic [NW-1:0] a, input logic [NW-1:0] b);
    reset     = rst;
    req_valid = v;
    rsp_ready = rr;
    req_a     = a;
    req_b     = b;
  endtask

  // Compare this cycle's outputs, then advance the model across the coming edge
  task automatic stepCycle();
    int           g;
    logic [N-1:0] exp_ready;
    flight_t      keep[$];
    #1;
    g = pickGrant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    checkOutput("req_ready", NW'(req_ready), NW'(exp_ready));
    checkOutput("rsp_valid", NW'(rsp_valid), NW'(m_rv));
    checkOutput("rsp_data", rsp_data, NW'(m_data));
    if (reset) begin
      resetModel();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_rv[i] && rsp_ready[i]) begin
          m_rv[i]   = 1'b0;
          m_busy[i] = 1'b0;
        end
      end
      if (g >= 0) begin
        m_busy[g] = 1'b1;
        m_rr      = (g + 1) % N;
        inflight.push_back('{id: g, val: refMul(req_a[g*W +: W], req_b[g*W +: W]), due: cyc + L + 1});
      end
      foreach (inflight[j]) begin
        if (inflight[j].due == cyc + 1) begin
          m_rv[inflight[j].id]   = 1'b1;
          m_data[inflight[j].id] = inflight[j].val;
        end else begin
          keep.push_back(inflight[j]);
        end
      end
      inflight = keep;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic randomCycle(input int vpct, input int rpct, input int rstpct);
    logic [N-1:0]  v;
    logic [N-1:0]  rr;
    logic [NW-1:0] a;
    logic [NW-1:0] b;
    for (int i = 0; i < N; i++) begin
      v[i]         = ($urandom_range(0, 99) < vpct);
      rr[i]        = ($urandom_range(0, 99) < rpct);
      a[i*W +: W]  = randOperand();
      b[i*W +: W]  = randOperand();
    end
    applyStimulus(($urandom_range(0, 99) < rstpct), v, rr, a, b);
    stepCycle();
  endtask

  logic [NW-1:0] av;
  logic [NW-1:0] bv;

  initial begin
    applyStimulus(1'b1, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    resetModel();
    applyStimulus(1'b1, 4'b1111, '0, '0, '0);
    stepCycle();

    // Single operation on requester 2: 7 * -3
    av = '0;
    bv = '0;
    av[2*W +: W] = 32'd7;
    bv[2*W +: W] = 32'hFFFF_FFFD;
    applyStimulus(1'b0, 4'b0100, 4'b1111, av, bv);
    stepCycle();
    applyStimulus(1'b0, 4'b0000, 4'b1111, '0, '0);
    stepCycle();
    checkOutput("single_valid", NW'(rsp_valid), NW'(4'b0100));
    checkOutput("single_data", NW'(rsp_data[2*W +: W]), NW'(32'hFFFF_FFEB));
    repeat (2) stepCycle();

    // Overflow cases held under backpressure, then released
    applyStimulus(1'b1, '0, '0, '0, '0);
    stepCycle();
    av = '0;
    bv = '0;
    av[0*W +: W] = 32'h7FFF_FFFF;
    bv[0*W +: W] = 32'd2;
    av[3*W +: W] = 32'h8000_0000;
    bv[3*W +: W] = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 4'b1001, 4'b0000, av, bv);
    repeat (2) stepCycle();
    applyStimulus(1'b0, 4'b0000, 4'b0000, '0, '0);
    repeat (2) stepCycle();
    checkOutput("ovf_pos", NW'(rsp_data[0*W +: W]), NW'(32'hFFFF_FFFE));
    checkOutput("ovf_neg", NW'(rsp_data[3*W +: W]), NW'(32'h8000_0000));
    applyStimulus(1'b0, 4'b0000, 4'b1111, '0, '0);
    repeat (2) stepCycle();

    // Backpressure on requester 1 while it keeps requesting
    av = '0;
    bv = '0;
    av[1*W +: W] = 32'd1234;
    bv[1*W +: W] = 32'hFFFF_FF00;
    applyStimulus(1'b0, 4'b0010, 4'b1101, av, bv);
    repeat (8) stepCycle();
    applyStimulus(1'b0, 4'b0010, 4'b1111, av, bv);
    repeat (4) stepCycle();

    // All requesters continuously valid with responses always accepted
    for (int c = 0; c < 40; c++) randomCycle(100, 100, 0);

    // Reset with operations in flight, then idle to confirm nothing emerges
    applyStimulus(1'b0, 4'b1111, 4'b0000, '0, '0);
    repeat (2) stepCycle();
    applyStimulus(1'b1, 4'b1111, 4'b0000, '0, '0);
    stepCycle();
    applyStimulus(1'b0, 4'b0000, 4'b1111, '0, '0);
    repeat (4) stepCycle();
    applyStimulus(1'b0, 4'b1111, 4'b1111, '0, '0);
    stepCycle();

    // Random traffic with occasional resets
    for (int c = 0; c < 400; c++) randomCycle(60, 50, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
